// File: rtl/div_pkg.sv
// Shared widths, state encoding and sizing helpers for the 16/8 divider datapath
// and its multiply-add reconstruction unit.
package div_pkg;

   localparam int QW_DEF = 16;
   localparam int BW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Accumulator holds Q*B + R without loss: QW+BW product bits plus one carry.
   function automatic int aw_calc(input int qw, input int bw);
      return qw + bw + 1;
   endfunction

   function automatic int cnt_width(input int bw);
      return ($clog2(bw) > 0) ? $clog2(bw) : 1;
   endfunction

endpackage

// File: rtl/mul_add_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand, then advance
// the multiplicand and multiplier by one bit.
module mul_add_step #(
   parameter int AW = 25,
   parameter int BW = 8
) (
   input  logic [AW-1:0] acc,
   input  logic [AW-1:0] mcand,
   input  logic [BW-1:0] mplier,
   output logic [AW-1:0] acc_nx,
   output logic [AW-1:0] mcand_nx,
   output logic [BW-1:0] mplier_nx
);

   always_comb begin
      acc_nx    = mplier[0] ? (acc + mcand) : acc;
      mcand_nx  = mcand << 1;
      mplier_nx = mplier >> 1;
   end

endmodule

// File: rtl/mul_add_16bit_seq.sv
// Rebuilds a dividend A = Q*B + R one multiplier bit per clock and flags
// quotient/remainder pairs that no legal 16/8 division could have produced.
module mul_add_16bit_seq
   import div_pkg::*;
#(
   parameter int QW = QW_DEF,
   parameter int BW = BW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [QW-1:0] q,
   input  logic [BW-1:0] b,
   input  logic [QW-1:0] r,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] a,
   output logic          ovf,
   output logic          rem_err
);

   localparam int AW = aw_calc(QW, BW);
   localparam int CW = cnt_width(BW);
   localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [AW-1:0] mcand_q, mcand_d;
   logic [BW-1:0] mplier_q, mplier_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_valid_q, out_valid_d;
   logic [QW-1:0] a_q, a_d;
   logic          ovf_q, ovf_d;
   logic          rem_err_q, rem_err_d;

   logic [AW-1:0] acc_nx;
   logic [AW-1:0] mcand_nx;
   logic [BW-1:0] mplier_nx;

   mul_add_step #(
      .AW (AW),
      .BW (BW)
   ) u_step (
      .acc       (acc_q),
      .mcand     (mcand_q),
      .mplier    (mplier_q),
      .acc_nx    (acc_nx),
      .mcand_nx  (mcand_nx),
      .mplier_nx (mplier_nx)
   );

   assign in_ready = (state_q == IDLE);

   always_comb begin
      // NOTE: every next-value signal is defaulted to its current value first,
      // so no path through the case leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      a_d         = a_q;
      ovf_d       = ovf_q;
      rem_err_d   = rem_err_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d   = BUSY;
               acc_d     = AW'(r);
               mcand_d   = AW'(q);
               mplier_d  = b;
               cnt_d     = '0;
               rem_err_d = (b == '0) || (r >= QW'(b));
            end
         end
         BUSY: begin
            acc_d    = acc_nx;
            mcand_d  = mcand_nx;
            mplier_d = mplier_nx;
            cnt_d    = cnt_q + CW'(1);
            // Last step: publish the final sum directly from the adder output.
            if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               a_d         = acc_nx[QW-1:0];
               ovf_d       = |acc_nx[AW-1:QW];
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         ovf_q       <= 1'b0;
         rem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         ovf_q       <= ovf_d;
         rem_err_q   <= rem_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign a         = a_q;
   assign ovf       = ovf_q;
   assign rem_err   = rem_err_q;

endmodule

// File: tb/tb_mul_add_16bit_seq.sv
// Directed vectors, handshake corner cases and a randomized divider-model run
// for the multiply-add reconstruction unit.
module tb_mul_add_16bit_seq;

   localparam int N_RAND = 1500;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] q;
   logic [7:0]  b;
   logic [15:0] r;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] a;
   logic        ovf;
   logic        rem_err;

   int checks;
   int failures;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  b;
      logic [15:0] r;
      logic [15:0] a;
      logic        ovf;
      logic        rem_err;
   } vec_t;

   vec_t vecs[5];

   mul_add_16bit_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .b         (b),
      .r         (r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a         (a),
      .ovf       (ovf),
      .rem_err   (rem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Presents operands, confirms the block is ready and returns just after the accept edge.
   task automatic start_op(input logic [15:0] tq, input logic [7:0] tb, input logic [15:0] tr);
      @(negedge clk);
      q        = tq;
      b        = tb;
      r        = tr;
      in_valid = 1'b1;
      check("accept_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      q        = 16'hDEAD;
      b        = 8'hBE;
      r        = 16'hBEEF;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 50) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) break;
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("post_hs_out_valid", out_valid, 1'b0);
      check("post_hs_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      int lat;
      int cyc;
      int issued;
      int received;
      int seen;
      logic accepted;
      logic [15:0] exp_q[$];
      logic [15:0] dvd;
      logic [15:0] exp_a;

      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      q         = '0;
      b         = '0;
      r         = '0;

      vecs[0] = '{q: 16'h1234, b: 8'h05, r: 16'h0003, a: 16'h5B07, ovf: 1'b0, rem_err: 1'b0};
      vecs[1] = '{q: 16'hFFFF, b: 8'hFF, r: 16'h00FE, a: 16'hFFFF, ovf: 1'b1, rem_err: 1'b0};
      vecs[2] = '{q: 16'h0007, b: 8'h00, r: 16'h0000, a: 16'h0000, ovf: 1'b0, rem_err: 1'b1};
      vecs[3] = '{q: 16'h0002, b: 8'h04, r: 16'h0004, a: 16'h000C, ovf: 1'b0, rem_err: 1'b1};
      vecs[4] = '{q: 16'h0002, b: 8'h04, r: 16'h0003, a: 16'h000B, ovf: 1'b0, rem_err: 1'b0};

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_a", a, 16'h0000);
      check("rst_ovf", ovf, 1'b0);
      check("rst_rem_err", rem_err, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed table.
      for (int i = 0; i < 5; i++) begin
         start_op(vecs[i].q, vecs[i].b, vecs[i].r);
         wait_done(lat);
         check($sformatf("vec%0d_latency", i), lat, 8);
         check($sformatf("vec%0d_a", i), a, vecs[i].a);
         check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
         check($sformatf("vec%0d_rem_err", i), rem_err, vecs[i].rem_err);
         handshake();
      end

      // Backpressure: result held, stray in_valid pulses ignored.
      start_op(16'h0003, 8'h07, 16'h0002);
      wait_done(lat);
      check("bp_latency", lat, 8);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = k[0];
         q        = 16'h0100 + 16'(k);
         b        = 8'h03;
         r        = 16'h0001;
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_a", a, 16'h0017);
         check("bp_ovf", ovf, 1'b0);
         check("bp_rem_err", rem_err, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      handshake();
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid || !in_ready) seen++;
      end
      check("bp_no_phantom_op", seen, 0);

      // Reset during the fourth BUSY cycle abandons the operation.
      start_op(16'h1234, 8'h05, 16'h0003);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_a", a, 16'h0000);
      check("midrst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst_no_result", seen, 0);
      start_op(16'h0010, 8'h10, 16'h0001);
      wait_done(lat);
      check("midrst_next_latency", lat, 8);
      check("midrst_next_a", a, 16'h0101);
      check("midrst_next_rem_err", rem_err, 1'b0);
      handshake();

      // Random operands from a golden 16/8 division, with valid/ready stalls.
      issued   = 0;
      received = 0;
      accepted = 1'b0;
      cyc      = 0;
      while (received < N_RAND && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         if (accepted) begin
            in_valid = 1'b0;
            accepted = 1'b0;
         end
         if (!in_valid && issued < N_RAND && $urandom_range(0, 3) != 0) begin
            dvd      = 16'($urandom_range(0, 65535));
            b        = 8'($urandom_range(1, 255));
            q        = dvd / 16'(b);
            r        = dvd % 16'(b);
            in_valid = 1'b1;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(16'(q * 16'(b) + r));
            issued++;
            accepted = 1'b1;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("rand_unexpected_result", 1'b1, 1'b0);
            end else begin
               exp_a = exp_q.pop_front();
               check("rand_a", a, exp_a);
               check("rand_ovf", ovf, 1'b0);
               check("rand_rem_err", rem_err, 1'b0);
            end
            received++;
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("rand_received", received, N_RAND);
      check("rand_pending", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
